// File: rtl/i2c_master_arb.sv
// Grant arbiter sharing one I2C master engine among NREQ requesters on a multi-master bus.
// Optional feature: define I2C_ARB_PRIO0_EN to give requester 0 fixed priority over the round-robin.
module i2c_master_arb #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int CNTW     = 16,
  parameter int GAP      = 64,
  parameter int HOLD_MAX = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            bby,
  input  logic            lost,
  input  logic            eng_idle,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_vld,
  output logic [IDW-1:0]  gnt_id,
  output logic            tout,
  output logic            retry
);

  localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(GAP - 1);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [CNTW-1:0] CNT_MAX   = '1;
  localparam logic [IDW-1:0]  LAST_ID   = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, WFREE, GRANT, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [NREQ-1:0] gnt_reg, gnt_next, mask_reg, mask_next, mask_set, elig, win_oh;
  logic [IDW-1:0]  id_reg, id_next, rr_reg, rr_next, win, win_lo, win_hi, rr_adv;
  logic            have_hi;
  logic [CNTW-1:0] gap_reg, gap_next, hold_reg, hold_next;
  logic            tout_reg, tout_next, retry_reg, retry_next;

  assign elig = req & ~mask_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_bit
      assign win_oh[gi]    = (win == IDW'(gi));
      // a requester must drop req to clear its timeout lockout
      assign mask_next[gi] = (mask_reg[gi] | mask_set[gi]) & req[gi];
    end
  endgenerate

  // Round-robin: lowest eligible index at or above rr_reg, else lowest below it.
  always_comb begin
    win_lo  = '0;
    win_hi  = '0;
    have_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        if (IDW'(i) >= rr_reg) begin
          win_hi  = IDW'(i);
          have_hi = 1'b1;
        end else begin
          win_lo = IDW'(i);
        end
      end
    end
    win    = have_hi ? win_hi : win_lo;
    rr_adv = (win == LAST_ID) ? '0 : win + IDW'(1);
`ifdef I2C_ARB_PRIO0_EN
    if (elig[0]) begin
      win    = '0;
      rr_adv = rr_reg;
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    id_next    = id_reg;
    rr_next    = rr_reg;
    gap_next   = gap_reg;
    hold_next  = hold_reg;
    tout_next  = 1'b0;
    retry_next = 1'b0;
    mask_set   = '0;
    case (state_reg)
      IDLE: begin
        gap_next = '0;
        if (|elig) state_next = WFREE;
      end
      WFREE: begin
        if (!(|elig)) begin
          state_next = IDLE;
          gap_next   = '0;
        end else if (bby) begin
          gap_next = '0;
        end else if (gap_reg >= GAP_LAST && eng_idle) begin
          state_next = GRANT;
          gnt_next   = win_oh;
          id_next    = win;
          rr_next    = rr_adv;
          hold_next  = '0;
          gap_next   = '0;
        end else begin
          gap_next = (gap_reg == CNT_MAX) ? gap_reg : gap_reg + CNTW'(1);
        end
      end
      GRANT: begin
        if (lost || (HOLD_MAX != 0 && hold_reg == HOLD_LAST) || !req[id_reg]) begin
          state_next = DRAIN;
          gnt_next   = '0;
          id_next    = '0;
          if (lost) begin
            retry_next = 1'b1;
          end else if (HOLD_MAX != 0 && hold_reg == HOLD_LAST) begin
            tout_next        = 1'b1;
            mask_set[id_reg] = 1'b1;
          end
        end else begin
          hold_next = (hold_reg == CNT_MAX) ? hold_reg : hold_reg + CNTW'(1);
        end
      end
      DRAIN: begin
        if (eng_idle && !bby) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      id_reg    <= '0;
      rr_reg    <= '0;
      gap_reg   <= '0;
      hold_reg  <= '0;
      mask_reg  <= '0;
      tout_reg  <= 1'b0;
      retry_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      id_reg    <= id_next;
      rr_reg    <= rr_next;
      gap_reg   <= gap_next;
      hold_reg  <= hold_next;
      mask_reg  <= mask_next;
      tout_reg  <= tout_next;
      retry_reg <= retry_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_vld = |gnt_reg;
  assign gnt_id  = id_reg;
  assign tout    = tout_reg;
  assign retry   = retry_reg;

endmodule

// File: tb/tb_i2c_master_arb.sv
// Bench for i2c_master_arb: directed scenarios with literal expectations plus random traffic
// compared every cycle against a transaction-level model of the grant rules.
module tb_i2c_master_arb;
  localparam int NREQ = 4, IDW = 2, CNTW = 16, GAP = 8, HOLD_MAX = 100;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            bby = 1'b0, lost = 1'b0, eng_idle = 1'b1;
  logic [NREQ-1:0] gnt;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_id;
  logic            tout, retry;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  i2c_master_arb #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW), .GAP(GAP), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .bby(bby), .lost(lost), .eng_idle(eng_idle),
    .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id), .tout(tout), .retry(retry)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the engine, how long the bus has been quiet, how long the grant has lasted.
  int        m_owner = -1, m_quiet = 0, m_held = 0, m_rr = 0, m_w = 0;
  bit        m_wait = 0, m_clean = 0, m_tout = 0, m_retry = 0;
  bit [NREQ-1:0] m_mask = '0, m_elig, m_set;

  function automatic int pick(input bit [NREQ-1:0] e, input int rr);
`ifdef I2C_ARB_PRIO0_EN
    if (e[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) if (e[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_quiet = 0; m_held = 0; m_rr = 0;
      m_wait = 0; m_clean = 0; m_tout = 0; m_retry = 0; m_mask = '0;
    end else begin
      m_elig  = req & ~m_mask;
      m_set   = '0;
      m_tout  = 0;
      m_retry = 0;
      if (m_owner >= 0) begin
        if (lost) begin
          m_retry = 1; m_owner = -1; m_clean = 1;
        end else if (HOLD_MAX != 0 && m_held == HOLD_MAX - 1) begin
          m_tout = 1; m_set[m_owner] = 1; m_owner = -1; m_clean = 1;
        end else if (!req[m_owner]) begin
          m_owner = -1; m_clean = 1;
        end else begin
          m_held++;
        end
      end else if (m_clean) begin
        if (eng_idle && !bby) m_clean = 0;
      end else if (m_wait) begin
        if (m_elig == 0) begin
          m_wait = 0; m_quiet = 0;
        end else if (bby) begin
          m_quiet = 0;
        end else if (m_quiet >= GAP - 1 && eng_idle) begin
          m_w = pick(m_elig, m_rr);
          m_owner = m_w; m_held = 0; m_wait = 0; m_quiet = 0;
`ifdef I2C_ARB_PRIO0_EN
          if (m_w != 0) m_rr = (m_w + 1) % NREQ;
`else
          m_rr = (m_w + 1) % NREQ;
`endif
        end else begin
          m_quiet++;
        end
      end else if (m_elig != 0) begin
        m_wait = 1; m_quiet = 0;
      end
      m_mask = (m_mask | m_set) & req;
    end
  end

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      int exp_v, act_v;
      exp_v = ((m_owner >= 0 ? (1 << m_owner) : 0) << 5) | ((m_owner >= 0 ? m_owner : 0) << 3)
            | ((m_owner >= 0 ? 1 : 0) << 2) | (int'(m_tout) << 1) | int'(m_retry);
      act_v = (int'(gnt) << 5) | (int'(gnt_id) << 3) | (int'(gnt_vld) << 2) | (int'(tout) << 1) | int'(retry);
      check("model", act_v, exp_v);
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    req = '0; bby = 0; lost = 0; eng_idle = 1;
    rst = 1;
    tick; tick;
    rst = 0;
    check("reset_gnt", int'(gnt), 0);
    check("reset_flags", int'({gnt_vld, gnt_id, tout, retry}), 0);
  endtask

  task automatic wait_grant(input string name, output int n);
    n = 0;
    while (!gnt_vld && n < 1000) begin
      tick;
      n++;
    end
    check(name, int'(gnt_vld), 1);
  endtask

  int n, nv;
  int exp_seq[5];

  initial begin
`ifdef I2C_ARB_PRIO0_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    @(negedge clk);
    do_reset;

    // single requester latency and release
    req = 4'b0001;
    wait_grant("single_wait", n);
    check("single_latency", n, GAP + 1);
    check("single_gnt", int'(gnt), 1);
    req = 4'b0000;
    tick;
    check("single_release", int'(gnt), 0);

    // round-robin order, each grant released after 10 cycles
    do_reset;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant("rr_wait", n);
      check("rr_id", int'(gnt_id), exp_seq[i]);
      repeat (9) tick;
      nv = int'(gnt_id);
      req[nv] = 1'b0;
      tick;
      check("rr_release", int'(gnt_vld), 0);
      req[nv] = 1'b1;
    end

    // bus-busy pulse restarts the gap count
    do_reset;
    req = 4'b0010;
    repeat (GAP - 2) tick;
    bby = 1;
    tick;
    bby = 0;
    wait_grant("bby_wait", n);
    check("bby_delay", n, GAP);
    check("bby_gnt", int'(gnt), 2);

    // timeout and lockout until req drops
    do_reset;
    req = 4'b0100;
    wait_grant("tout_wait", n);
    check("tout_gnt", int'(gnt), 4);
    n = 0;
    while (gnt_vld && n < 500) begin
      n++;
      tick;
    end
    check("tout_len", n, HOLD_MAX);
    check("tout_pulse", int'(tout), 1);
    tick;
    check("tout_one_cycle", int'(tout), 0);
    nv = 0;
    repeat (3 * GAP + 20) begin
      tick;
      nv += int'(gnt_vld);
    end
    check("tout_no_regrant", nv, 0);
    req = 4'b0000;
    tick;
    req = 4'b0100;
    wait_grant("tout_regrant", n);

    // arbitration loss -> retry, regrant to next candidate
    do_reset;
    req = 4'b0011;
    wait_grant("lost_wait", n);
    check("lost_first_id", int'(gnt_id), 0);
    repeat (5) tick;
    lost = 1;
    tick;
    lost = 0;
    check("lost_retry", int'(retry), 1);
    check("lost_gnt", int'(gnt), 0);
    tick;
    check("lost_retry_pulse", int'(retry), 0);
    wait_grant("lost_regrant", n);
`ifdef I2C_ARB_PRIO0_EN
    check("lost_next_id", int'(gnt_id), 0);
`else
    check("lost_next_id", int'(gnt_id), 1);
`endif

    // asynchronous reset during a grant
    do_reset;
    req = 4'b0001;
    wait_grant("areset_wait", n);
    repeat (3) tick;
    #2 rst = 1;
    #1;
    check("areset_gnt", int'(gnt), 0);
    check("areset_vld_id", int'({gnt_vld, gnt_id}), 0);
    @(negedge clk);
    tick;
    rst = 0;
    wait_grant("areset_regrant", n);
    check("areset_latency", n, GAP + 1);

    // random traffic with frequent losses
    do_reset;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NREQ; b++) if ($urandom_range(47, 0) == 0) req[b] = ~req[b];
      bby      = ($urandom_range(9, 0) == 0);
      lost     = ($urandom_range(39, 0) == 0);
      eng_idle = ($urandom_range(5, 0) != 0);
      tick;
    end
    // random traffic with long holds so timeouts occur
    lost = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NREQ; b++) if ($urandom_range(199, 0) == 0) req[b] = ~req[b];
      bby      = ($urandom_range(11, 0) == 0);
      eng_idle = ($urandom_range(7, 0) != 0);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
